rv_mem_arb: RTL and testbench

- Arbitrates the core's instruction-fetch port and data-memory port onto one shared single-port memory with a req/ack handshake. This lets the 5-stage rv_cpu run against a unified, variable-latency memory.
- Sits between rv_cpu (imem_addr / core2dmem_req side) and the memory model or bus.
- Generates stall signals for the IF and MA stages while their access is outstanding.

---
 rtl/rv_mem_arb_pkg.sv | 34 +++
 rtl/rv_mem_arb.sv | 161 ++++++++++++++++
 tb/tb_rv_mem_arb.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_mem_arb_pkg.sv
// Shared types and defaults for rv_mem_arb: the core data-request struct,
// the arbiter state encoding and the registered shared-memory request bundle.
package rv_mem_arb_pkg;

    localparam int CORE_ADDR_W          = 32;
    localparam int CORE_DATA_W          = 32;
    localparam int ARB_STARVE_LIMIT_DEF = 4;
    localparam int ARB_MAX_WAIT_DEF     = 16;

    typedef struct packed {
        logic                   rd_en;
        logic                   wr_en;
        logic [CORE_ADDR_W-1:0] addr;
        logic [CORE_DATA_W-1:0] wr_data;
    } t_core2mem_req;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } t_arb_state;

    typedef struct packed {
        logic                   req;
        logic                   we;
        logic [CORE_ADDR_W-1:0] addr;
        logic [CORE_DATA_W-1:0] wdata;
    } t_mem_bus_req;

    function automatic logic dmem_active(input t_core2mem_req r);
        return r.rd_en | r.wr_en;
    endfunction

endpackage

// File: rtl/rv_mem_arb.sv
// Arbitrates instruction fetch and data accesses onto one shared single-port
// memory, one access outstanding at a time, with fetch anti-starvation and timeout.
module rv_mem_arb
    import rv_mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT_DEF,
    parameter int MAX_WAIT     = ARB_MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rd_data,
    output logic              if_valid,
    input  t_core2mem_req     core2dmem_req,
    output logic [DATA_W-1:0] dmem_rd_data,
    output logic              dmem_done,
    output logic              stall_if,
    output logic              stall_ma,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err
);

    localparam int WAIT_W   = $clog2(MAX_WAIT) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT) + 1;

    localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
    localparam logic [WAIT_W-1:0]   WAIT_SAT   = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0]   WAIT_ZERO  = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0]   WAIT_ONE   = WAIT_W'(1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_SAT = {STARVE_W{1'b1}};
    localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);
    localparam logic [DATA_W-1:0]   DATA_ZERO  = {DATA_W{1'b0}};

    t_arb_state          state_r, state_s;
    t_mem_bus_req        bus_r, bus_s;
    logic [WAIT_W-1:0]   wait_cnt_r, wait_cnt_s;
    logic [STARVE_W-1:0] starve_cnt_r, starve_cnt_s;
    logic [DATA_W-1:0]   if_rd_data_r, if_rd_data_s;
    logic [DATA_W-1:0]   dmem_rd_data_r, dmem_rd_data_s;
    logic                if_valid_r, if_valid_s;
    logic                dmem_done_r, dmem_done_s;
    logic                mem_err_r, mem_err_s;
    logic                timeout_s;
    logic                dmem_active_s;

    assign dmem_active_s = dmem_active(core2dmem_req);

    // Grant selection in IDLE, completion/timeout handling while busy
    always_comb begin
        state_s        = state_r;
        bus_s          = bus_r;
        wait_cnt_s     = wait_cnt_r;
        starve_cnt_s   = starve_cnt_r;
        if_rd_data_s   = if_rd_data_r;
        dmem_rd_data_s = dmem_rd_data_r;
        if_valid_s     = 1'b0;
        dmem_done_s    = 1'b0;
        mem_err_s      = mem_err_r;
        timeout_s      = 1'b0;
        case (state_r)
            IDLE: begin
                wait_cnt_s = WAIT_ZERO;
                // Data wins unless a waiting fetch has already been passed over STARVE_LIMIT times
                if (dmem_active_s && (!if_req || (starve_cnt_r < STARVE_LIM))) begin
                    bus_s.req   = 1'b1;
                    bus_s.we    = core2dmem_req.wr_en;
                    bus_s.addr  = core2dmem_req.addr;
                    bus_s.wdata = core2dmem_req.wr_data;
                    state_s     = BUSY_D;
                    if (if_req) begin
                        starve_cnt_s = (starve_cnt_r == STARVE_SAT) ? starve_cnt_r : starve_cnt_r + STARVE_ONE;
                    end else begin
                        starve_cnt_s = starve_cnt_r;
                    end
                end else if (if_req) begin
                    bus_s.req    = 1'b1;
                    bus_s.we     = 1'b0;
                    bus_s.addr   = CORE_ADDR_W'(if_addr);
                    bus_s.wdata  = {CORE_DATA_W{1'b0}};
                    state_s      = BUSY_I;
                    starve_cnt_s = {STARVE_W{1'b0}};
                end else begin
                    bus_s.req = 1'b0;
                    state_s   = IDLE;
                end
            end
            BUSY_I, BUSY_D: begin
                timeout_s = !mem_ack && (wait_cnt_r == WAIT_LAST);
                if (mem_ack || timeout_s) begin
                    bus_s.req  = 1'b0;
                    state_s    = IDLE;
                    wait_cnt_s = WAIT_ZERO;
                    mem_err_s  = mem_err_r | timeout_s;
                    // A timed-out access still completes, returning zero data
                    if (state_r == BUSY_I) begin
                        if_valid_s   = 1'b1;
                        if_rd_data_s = mem_ack ? mem_rdata : DATA_ZERO;
                    end else begin
                        dmem_done_s    = 1'b1;
                        dmem_rd_data_s = (mem_ack && !bus_r.we) ? mem_rdata : DATA_ZERO;
                    end
                end else begin
                    wait_cnt_s = (wait_cnt_r == WAIT_SAT) ? wait_cnt_r : wait_cnt_r + WAIT_ONE;
                end
            end
            default: begin
                state_s   = IDLE;
                bus_s.req = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= IDLE;
            bus_r          <= '{req: 1'b0, we: 1'b0, addr: {CORE_ADDR_W{1'b0}}, wdata: {CORE_DATA_W{1'b0}}};
            wait_cnt_r     <= WAIT_ZERO;
            starve_cnt_r   <= {STARVE_W{1'b0}};
            if_rd_data_r   <= DATA_ZERO;
            dmem_rd_data_r <= DATA_ZERO;
            if_valid_r     <= 1'b0;
            dmem_done_r    <= 1'b0;
            mem_err_r      <= 1'b0;
        end else begin
            state_r        <= state_s;
            bus_r          <= bus_s;
            wait_cnt_r     <= wait_cnt_s;
            starve_cnt_r   <= starve_cnt_s;
            if_rd_data_r   <= if_rd_data_s;
            dmem_rd_data_r <= dmem_rd_data_s;
            if_valid_r     <= if_valid_s;
            dmem_done_r    <= dmem_done_s;
            mem_err_r      <= mem_err_s;
        end
    end

    assign mem_req      = bus_r.req;
    assign mem_we       = bus_r.we;
    assign mem_addr     = bus_r.addr[ADDR_W-1:0];
    assign mem_wdata    = bus_r.wdata[DATA_W-1:0];
    assign if_rd_data   = if_rd_data_r;
    assign if_valid     = if_valid_r;
    assign dmem_rd_data = dmem_rd_data_r;
    assign dmem_done    = dmem_done_r;
    assign mem_err      = mem_err_r;

    // The done pulse releases the stall in the cycle the result is consumed
    assign stall_if = if_req & ~if_valid_r;
    assign stall_ma = dmem_active_s & ~dmem_done_r;

endmodule

// File: tb/tb_rv_mem_arb.sv
// Self-checking bench for rv_mem_arb: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level reference model.
module tb_rv_mem_arb;
    import rv_mem_arb_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [31:0]   if_addr;
    logic [31:0]   if_rd_data;
    logic          if_valid;
    t_core2mem_req c2m;
    logic [31:0]   dmem_rd_data;
    logic          dmem_done;
    logic          stall_if;
    logic          stall_ma;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          mem_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_arr [128];
    logic [31:0] ref_mem [128];
    int          lat_cfg    = 0;
    int          lat_cur    = 0;
    int          busy       = 0;
    bit          mem_manual = 1'b0;

    typedef struct {
        bit          is_fetch;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_data;
        int          exp_cyc;
        bit          exp_err;
    } vec_t;

    vec_t vecs [7];

    rv_mem_arb dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rd_data(if_rd_data), .if_valid(if_valid),
        .core2dmem_req(c2m), .dmem_rd_data(dmem_rd_data), .dmem_done(dmem_done),
        .stall_if(stall_if), .stall_ma(stall_ma),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Variable-latency memory: acks after lat_cur extra cycles, writes on ack
    always @(negedge clk) begin
        if (!mem_manual) begin
            if (mem_req) begin
                if (busy == 0) lat_cur = lat_cfg;
                if (busy == lat_cur) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_arr[mem_addr[8:2]];
                    if (mem_we) mem_arr[mem_addr[8:2]] = mem_wdata;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 32'hBAD0_BAD0;
                end
                busy++;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hBAD0_BAD0;
                busy      = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        if_req  = 1'b0;
        if_addr = 32'h0;
        c2m     = '0;
    endtask

    task automatic do_vec(input vec_t v);
        bit seen;
        lat_cfg = v.lat;
        if (v.is_fetch) begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end else begin
            c2m.rd_en   = !v.we;
            c2m.wr_en   = v.we;
            c2m.addr    = v.addr;
            c2m.wr_data = v.wdata;
        end
        #1;
        chk("vec_stall_at_req", {31'd0, v.is_fetch ? stall_if : stall_ma}, 32'd1);
        seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            tick();
            if (c == 1) begin
                chk("vec_mem_req", {31'd0, mem_req}, 32'd1);
                chk("vec_mem_addr", mem_addr, v.addr);
                chk("vec_mem_we", {31'd0, mem_we}, {31'd0, v.we});
                if (v.we) chk("vec_mem_wdata", mem_wdata, v.wdata);
            end
            if (v.is_fetch ? if_valid : dmem_done) begin
                seen = 1'b1;
                chk("vec_latency", c, v.exp_cyc);
                chk("vec_data", v.is_fetch ? if_rd_data : dmem_rd_data, v.exp_data);
                chk("vec_mem_err", {31'd0, mem_err}, {31'd0, v.exp_err});
                clear_inputs();
            end
        end
        if (!seen) begin
            chk("vec_done_timeout", 32'd0, 32'd1);
            clear_inputs();
        end
        tick();
    endtask

    initial begin
        int          d_cyc, i_cyc, seq_d, d_first, d_second, icount;
        bit          bad, p_req, p_i, p_d, p_dwe, kd, eiv, edd, w;
        logic [31:0] p_iaddr, p_daddr, p_dwdata;
        int          gkind, consec;
        vec_t        tv;

        rst = 1'b0;
        clear_inputs();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        for (int i = 0; i < 128; i++) mem_arr[i] = 32'h0;
        mem_arr[1] = 32'hDEAD_BEEF;
        mem_arr[2] = 32'h00A0_0093;
        mem_arr[5] = 32'h1234_5678;

        repeat (3) tick();
        chk("reset_flags", {25'd0, mem_req, mem_we, if_valid, dmem_done, mem_err, stall_if, stall_ma}, 32'd0);
        chk("reset_addr", mem_addr, 32'd0);
        chk("reset_rdata", if_rd_data | dmem_rd_data, 32'd0);
        rst = 1'b1;
        tick();

        vecs[0] = '{1'b1, 1'b0, 32'h8, 32'h0,         0, 32'h00A0_0093, 2, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h0, 32'd30,        2, 32'h0,         4, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'h0, 32'h0,         1, 32'd30,        3, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h14, 32'h0,        3, 32'h1234_5678, 5, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h4, 32'h0,         0, 32'hDEAD_BEEF, 2, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 32'h4, 32'hCAFE_F00D, 4, 32'h0,         6, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 32'h4, 32'h0,         2, 32'hCAFE_F00D, 4, 1'b0};
        for (int i = 0; i < 7; i++) do_vec(vecs[i]);

        // Simultaneous fetch and load: data first, fetch after the data done
        lat_cfg = 3;
        if_req = 1'b1; if_addr = 32'h14;
        c2m.rd_en = 1'b1; c2m.addr = 32'h0;
        #1;
        chk("both_stalls", {30'd0, stall_if, stall_ma}, 32'd3);
        d_cyc = -1; i_cyc = -1;
        for (int c = 1; c <= 20 && (d_cyc < 0 || i_cyc < 0); c++) begin
            tick();
            if (dmem_done) begin
                d_cyc = c;
                chk("both_load_data", dmem_rd_data, 32'd30);
                c2m = '0;
            end
            if (if_valid) begin
                i_cyc = c;
                chk("both_fetch_data", if_rd_data, 32'h1234_5678);
                if_req = 1'b0;
            end
        end
        chk("both_dmem_done_cycle", d_cyc, 32'd5);
        chk("both_if_valid_cycle", i_cyc, 32'd10);
        clear_inputs();
        tick();

        // Starvation: continuous loads with a fetch held pending
        lat_cfg = 0;
        if_req = 1'b1; if_addr = 32'h100;
        c2m.rd_en = 1'b1; c2m.addr = 32'h8;
        seq_d = 0; d_first = -1; d_second = -1; icount = 0;
        for (int c = 0; c < 80 && icount < 2; c++) begin
            tick();
            if (dmem_done) seq_d++;
            if (if_valid) begin
                if (icount == 0) d_first = seq_d;
                else d_second = seq_d;
                seq_d = 0;
                icount++;
            end
        end
        clear_inputs();
        chk("starve_first_run", d_first, 32'd4);
        chk("starve_second_run", d_second, 32'd4);
        tick();

        // Timeout on a fetch that never gets acked
        lat_cfg = 1000;
        if_req = 1'b1; if_addr = 32'h8;
        i_cyc = -1;
        for (int c = 1; c <= 40 && i_cyc < 0; c++) begin
            tick();
            if (if_valid) begin
                i_cyc = c;
                chk("timeout_data", if_rd_data, 32'd0);
                chk("timeout_err", {31'd0, mem_err}, 32'd1);
                if_req = 1'b0;
            end
        end
        chk("timeout_cycle", i_cyc, 32'd17);
        clear_inputs();
        tick();
        tv = '{1'b0, 1'b0, 32'h4, 32'h0, 1, 32'hCAFE_F00D, 3, 1'b1};
        do_vec(tv);

        // Reset in the second BUSY_D cycle, then a stray ack after release
        lat_cfg = 5;
        c2m.rd_en = 1'b1; c2m.addr = 32'h4;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_async_flags", {27'd0, mem_req, mem_we, if_valid, dmem_done, mem_err}, 32'd0);
        chk("rst_async_bus", mem_addr | mem_wdata, 32'd0);
        chk("rst_async_data", dmem_rd_data | if_rd_data, 32'd0);
        clear_inputs();
        mem_manual = 1'b1;
        mem_ack    = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h55AA_55AA;
        tick();
        mem_ack = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bad = bad | if_valid | dmem_done | mem_req;
            tick();
        end
        chk("late_ack_ignored", {31'd0, bad}, 32'd0);
        chk("late_ack_err", {31'd0, mem_err}, 32'd0);
        chk("late_ack_data", dmem_rd_data, 32'd0);
        mem_manual = 1'b0;
        tick();

        // Randomized traffic against a transaction-level model
        for (int i = 0; i < 128; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
        end
        p_req = 1'b0; p_i = 1'b0; p_d = 1'b0; p_dwe = 1'b0;
        p_iaddr = 32'h0; p_daddr = 32'h0; p_dwdata = 32'h0;
        gkind = 0; consec = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            tick();
            chk("rnd_mem_req", {31'd0, mem_req}, {31'd0, p_req ? !mem_ack : (p_i | p_d)});
            if (mem_req && !p_req) begin
                kd    = p_d && (!p_i || consec < 4);
                gkind = kd ? 2 : 1;
                if (kd) begin
                    if (p_i) consec++;
                end else begin
                    consec = 0;
                end
                chk("rnd_grant_addr", mem_addr, kd ? p_daddr : p_iaddr);
                chk("rnd_grant_we", {31'd0, mem_we}, {31'd0, kd & p_dwe});
            end
            eiv = p_req && mem_ack && (gkind == 1);
            edd = p_req && mem_ack && (gkind == 2);
            chk("rnd_if_valid", {31'd0, if_valid}, {31'd0, eiv});
            chk("rnd_dmem_done", {31'd0, dmem_done}, {31'd0, edd});
            if (eiv) chk("rnd_fetch_data", if_rd_data, ref_mem[p_iaddr[8:2]]);
            if (edd) begin
                if (p_dwe) begin
                    chk("rnd_store_data", dmem_rd_data, 32'd0);
                    ref_mem[p_daddr[8:2]] = p_dwdata;
                end else begin
                    chk("rnd_load_data", dmem_rd_data, ref_mem[p_daddr[8:2]]);
                end
            end
            lat_cfg = $urandom_range(0, 4);
            if (!if_req || if_valid) begin
                if ($urandom_range(0, 3) != 0) begin
                    if_req  = 1'b1;
                    if_addr = 32'h100 + (32'($urandom_range(0, 15)) << 2);
                end else begin
                    if_req = 1'b0;
                end
            end
            if (!(c2m.rd_en | c2m.wr_en) || dmem_done) begin
                if ($urandom_range(0, 4) != 0) begin
                    w           = ($urandom_range(0, 2) == 0);
                    c2m.rd_en   = !w;
                    c2m.wr_en   = w;
                    c2m.addr    = 32'($urandom_range(0, 15)) << 2;
                    c2m.wr_data = $urandom;
                end else begin
                    c2m = '0;
                end
            end
            #1;
            chk("rnd_stall_if", {31'd0, stall_if}, {31'd0, if_req & ~if_valid});
            chk("rnd_stall_ma", {31'd0, stall_ma}, {31'd0, (c2m.rd_en | c2m.wr_en) & ~dmem_done});
            p_req    = mem_req;
            p_i      = if_req;
            p_iaddr  = if_addr;
            p_d      = c2m.rd_en | c2m.wr_en;
            p_dwe    = c2m.wr_en;
            p_daddr  = c2m.addr;
            p_dwdata = c2m.wr_data;
        end
        chk("rnd_no_err", {31'd0, mem_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
